// File: rtl/squared_norm_pkg.sv
// Shared constants, types and bias arithmetic for the squared-log2 norm bank.
// Contents:
//   COLS, SUB_COLS, BIT_WIDTH, NUM_WAYS, ACC_WIDTH, BIAS_BIT_WIDTH : datapath sizing
//   LEFT_SHIFT_W, RIGHT_SHIFT_W, K_SHOT_W                            : scale field widths
//   CW, WW, SW, SCALE_W                                              : derived widths
//   code_t, way_idx_t, beat_sum_t, acc_t, bias_t                     : datapath types
//   compute_bias()                                                   : acc -> few-shot bias
package squared_norm_pkg;

    localparam int unsigned COLS           = 16;
    localparam int unsigned SUB_COLS       = 4;
    localparam int unsigned BIT_WIDTH      = 8;
    localparam int unsigned NUM_WAYS       = 8;
    localparam int unsigned ACC_WIDTH      = 24;
    localparam int unsigned BIAS_BIT_WIDTH = 14;
    localparam int unsigned LEFT_SHIFT_W   = 2;
    localparam int unsigned RIGHT_SHIFT_W  = 2;
    localparam int unsigned K_SHOT_W       = 4;

    localparam int unsigned CW      = $clog2(BIT_WIDTH);
    localparam int unsigned WW      = $clog2(NUM_WAYS);
    // Wide enough for COLS copies of the largest term 4**(BIT_WIDTH-1).
    localparam int unsigned SW      = $clog2((4 ** (BIT_WIDTH - 1)) * COLS) + 1;
    // Headroom for the largest left shift of a full accumulator.
    localparam int unsigned SCALE_W = ACC_WIDTH + 2 ** LEFT_SHIFT_W;

    typedef logic [CW-1:0]                    code_t;
    typedef logic [WW-1:0]                    way_idx_t;
    typedef logic [SW-1:0]                    beat_sum_t;
    typedef logic [ACC_WIDTH-1:0]             acc_t;
    typedef logic signed [BIAS_BIT_WIDTH-1:0] bias_t;

    // bias = -(scaled acc)/2, clamped at the most negative representable value.
    function automatic bias_t compute_bias(
        input acc_t                    acc,
        input logic                    shift_right,
        input logic [LEFT_SHIFT_W-1:0] left_shift,
        input logic [RIGHT_SHIFT_W-1:0] right_shift,
        input logic [K_SHOT_W-1:0]     k_shot_div
    );
        logic [SCALE_W-1:0] s;
        logic [SCALE_W-1:0] neg;
        s = shift_right ? (SCALE_W'(acc) >> right_shift) : (SCALE_W'(acc) << left_shift);
        s = s >> k_shot_div;
        s = s >> 1;
        neg = -s;
        if (s > SCALE_W'(2 ** (BIAS_BIT_WIDTH - 1))) begin
            return {1'b1, {(BIAS_BIT_WIDTH - 1){1'b0}}};
        end
        return bias_t'(neg[BIAS_BIT_WIDTH-1:0]);
    endfunction

endpackage

// File: rtl/sq_log2_col_adder.sv
// Combinational sum of 4**code over the active columns of one beat.
// Ports:
//   code     : per-column log2 magnitudes
//   zero     : per-column force-to-zero mask
//   mode_4x4 : only columns 0..SUB_COLS-1 contribute
//   beat_sum : sum of (zero[c] ? 0 : 1 << 2*code[c]) over active columns
module sq_log2_col_adder
    import squared_norm_pkg::*;
(
    input  code_t [COLS-1:0] code,
    input  logic  [COLS-1:0] zero,
    input  logic             mode_4x4,
    output beat_sum_t        beat_sum
);

    always_comb begin
        beat_sum = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            if (!zero[c] && (!mode_4x4 || (c < SUB_COLS))) begin
                beat_sum = beat_sum + (beat_sum_t'(1) << (2 * code[c]));
            end
        end
    end

endmodule

// File: rtl/squared_log2_norm_bank.sv
// Bank of NUM_WAYS squared-log2 accumulators with per-way few-shot bias readout.
// Two-stage pipeline: S1 registers the beat sum, S2 read-modify-writes acc[way].
// Optional feature macro: SQNORM_ACC_SATURATE_EN (saturating add + sticky acc_overflow).
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   in_valid/in_ready              : beat handshake (in_ready low only during clear_all)
//   in_way, in_code, in_zero       : target way, per-column codes, per-column zero mask
//   in_last, in_4x4_mode           : final beat of way, restrict to SUB_COLS columns
//   clear_way/clear_idx, clear_all : zero one way / all ways
//   shift_right, left_shift, right_shift, k_shot_div : bias scaling
//   rd_req/rd_way -> rd_valid/rd_bias : one-cycle bias read
//   way_done, acc_overflow         : per-way status
module squared_log2_norm_bank
    import squared_norm_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  way_idx_t                 in_way,
    input  code_t [COLS-1:0]         in_code,
    input  logic  [COLS-1:0]         in_zero,
    input  logic                     in_last,
    input  logic                     in_4x4_mode,
    input  logic                     clear_way,
    input  way_idx_t                 clear_idx,
    input  logic                     clear_all,
    input  logic                     shift_right,
    input  logic [LEFT_SHIFT_W-1:0]  left_shift,
    input  logic [RIGHT_SHIFT_W-1:0] right_shift,
    input  logic [K_SHOT_W-1:0]      k_shot_div,
    input  logic                     rd_req,
    input  way_idx_t                 rd_way,
    output logic                     rd_valid,
    output bias_t                    rd_bias,
    output logic [NUM_WAYS-1:0]      way_done,
    output logic [NUM_WAYS-1:0]      acc_overflow
);

    typedef logic [ACC_WIDTH:0] acc_ext_t;

    beat_sum_t           beat_sum;
    logic                s1_valid_q;
    way_idx_t            s1_way_q;
    logic                s1_last_q;
    beat_sum_t           s1_sum_q;
    acc_t                acc_q [NUM_WAYS];
    acc_t                acc_d [NUM_WAYS];
    logic [NUM_WAYS-1:0] done_q, done_d;
    logic                rd_valid_q;
    bias_t               rd_bias_q;
    acc_ext_t            sum_ext;
    acc_t                upd_val;

    assign in_ready = !clear_all;

    sq_log2_col_adder u_col_adder (
        .code     (in_code),
        .zero     (in_zero),
        .mode_4x4 (in_4x4_mode),
        .beat_sum (beat_sum)
    );

    // S1
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= in_valid && in_ready;
        end
    end

    always_ff @(posedge clk) begin
        s1_way_q  <= in_way;
        s1_last_q <= in_last;
        s1_sum_q  <= beat_sum;
    end

    // S2 add; the carry out is only meaningful in the saturating build.
    assign sum_ext = {1'b0, acc_q[s1_way_q]} + acc_ext_t'(s1_sum_q);

`ifdef SQNORM_ACC_SATURATE_EN
    logic [NUM_WAYS-1:0] ovf_q, ovf_d;
    assign upd_val = sum_ext[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_ext[ACC_WIDTH-1:0];
`else
    assign upd_val = sum_ext[ACC_WIDTH-1:0];
`endif

    // Clears are applied after the update so they win on the same way.
    always_comb begin
        for (int w = 0; w < NUM_WAYS; w++) begin
            acc_d[w] = acc_q[w];
        end
        done_d = done_q;
`ifdef SQNORM_ACC_SATURATE_EN
        ovf_d = ovf_q;
`endif
        if (s1_valid_q) begin
            acc_d[s1_way_q] = upd_val;
            if (s1_last_q) begin
                done_d[s1_way_q] = 1'b1;
            end
`ifdef SQNORM_ACC_SATURATE_EN
            if (sum_ext[ACC_WIDTH]) begin
                ovf_d[s1_way_q] = 1'b1;
            end
`endif
        end
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (clear_all || (clear_way && (clear_idx == way_idx_t'(w)))) begin
                acc_d[w]  = '0;
                done_d[w] = 1'b0;
`ifdef SQNORM_ACC_SATURATE_EN
                ovf_d[w] = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                acc_q[w] <= '0;
            end
            done_q <= '0;
        end else begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                acc_q[w] <= acc_d[w];
            end
            done_q <= done_d;
        end
    end

`ifdef SQNORM_ACC_SATURATE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
    assign acc_overflow = ovf_q;
`else
    assign acc_overflow = '0;
`endif

    // Read uses the pre-edge accumulator, so a same-edge S2 write is not visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_bias_q  <= '0;
        end else begin
            rd_valid_q <= rd_req;
            if (rd_req) begin
                rd_bias_q <= compute_bias(acc_q[rd_way], shift_right, left_shift,
                                          right_shift, k_shot_div);
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_bias  = rd_bias_q;
    assign way_done = done_q;

endmodule
